vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
Downstream consumer of the pixel cross-clock FIFO, running in the 25 MHz pixel domain. Generates 640x480@60 VGA timing and drives rd_fifo only during active video. Registers the FIFO pixel data onto the VGA output pins, aligned with hsync, vsync and de. Blanks any pixel slot the FIFO cannot supply and counts those underflows.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  pixel clock, 25 MHz
rst  in  1  asynchronous, active-low reset
en  in  1  level; 1 = run video, 0 = stop at the next frame end
fifo_empty  in  1  FIFO empty flag, rd_clk domain
pixel_r_in  in  8  FIFO dout red, valid the cycle after rd_fifo
pixel_g_in  in  8  FIFO dout green
pixel_b_in  in  8  FIFO dout blue
rd_fifo  out  1  FIFO read enable
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  active-video qualifier
vga_r  out  8  red output
vga_g  out  8  green output
vga_b  out  8  blue output
frame_start  out  1  one-cycle pulse, coincident with output pixel (0,0)
underflow  out  1  sticky flag: a pixel slot was missed
underflow_cnt  out  16  saturating count of missed pixel slots

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; h_cnt=v_cnt=0; pipeline cleared; rd_fifo=0; hsync=vsync=~SYNC_POL; de=0; vga_rgb=0; frame_start=0; underflow=0; underflow_cnt=0.
- Counters: h_cnt runs 0..H_TOT-1 (H_TOT=800 at defaults). v_cnt increments when h_cnt wraps and runs 0..V_TOT-1 (V_TOT=525). Counters advance only in RUN and are held at 0 otherwise.
- Active window: act = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE) && state==RUN.
- Raw hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751 at defaults.
- Raw vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491 at defaults.
- FSM:
  - IDLE: when en=1, go to WAIT_FILL.
  - WAIT_FILL: when en=1 and fifo_empty=0, go to RUN. Counters start at (0,0) on the first RUN cycle. If en=0, return to IDLE.
  - RUN: if en=0 is sampled at any point, set stop_pending. At h_cnt=H_TOT-1, v_cnt=V_TOT-1 with stop_pending set, go to IDLE and clear stop_pending. A re-assertion of en does not cancel stop_pending.
- rd_fifo is combinational: rd_fifo = act && ~fifo_empty. It is never asserted during blanking, IDLE or WAIT_FILL.
- Pipeline latency is 2 cycles from counter position to pins:
  - cycle N: counter at position P, rd_fifo issued;
  - cycle N+1: FIFO dout holds pixel P;
  - edge N+2: vga_rgb, de, hsync and vsync are registered together.
  - Raw sync, act and the read-issued bit are delayed through 2 registers to match.
- Output pixel: if the delayed act=1 and the delayed read-issued=1, vga_rgb = pixel_*_in. Otherwise vga_rgb = 0, so blanking always outputs black.
- Underflow: a cycle with act=1 and fifo_empty=1 is a missed slot.
  - The slot outputs black; de stays 1 to preserve timing.
  - underflow is set to 1 and stays set until reset.
  - underflow_cnt increments and saturates at 0xFFFF.
  - The FIFO is not re-synchronised; subsequent pixels shift.
- frame_start = 1 for the single cycle on which the pins carry pixel (0,0).
- Outside RUN, and for the 2 drain cycles after RUN ends: syncs are deasserted, de=0, rgb=0.
- Simultaneous events: a stop_pending frame end coinciding with en=1 still goes to IDLE. The next frame starts via WAIT_FILL.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the timing constants and derived H_TOT/V_TOT;
  - the counter widths (10 bits each);
  - the state enum {IDLE, WAIT_FILL, RUN}.
- One natural sub-module, vga_sync_counter: h/v counters, raw hsync/vsync, act and end-of-frame strobe.
- The top level holds the FSM, rd_fifo gating, the alignment pipeline, the output registers and the underflow logic.

Test Plan:
1. Hold rst=0, then release with en=0 -> all outputs at reset values; rd_fifo=0; hsync=vsync=1 indefinitely.
2. en=1, fifo_empty=0, pixel_in = incrementing pattern -> RUN one cycle after WAIT_FILL.
   - 480 de bursts of 640 cycles each; hsync low 96 cycles starting 656 cycles after de rises.
   - vsync low for 2 lines (1600 cycles); frame period 420000 cycles.
   - frame_start once per frame; vga_rgb equals the value present on pixel_in one cycle earlier.
3. Force fifo_empty=1 for 3 active cycles on line 10 -> rd_fifo=0 for those cycles.
   - 3 black pixels with de=1; underflow=1, underflow_cnt=3.
   - Timing is unaffected.
4. Drop en at line 200 of a frame -> the frame completes to v_cnt=524, h_cnt=799.
   - Then IDLE: de=0, syncs deasserted, no further rd_fifo.
5. Assert rst mid-line while in RUN -> outputs reset immediately (asynchronously); underflow_cnt clears to 0.
   - After release with en=1 and FIFO non-empty, timing restarts from (0,0).
6. Keep fifo_empty=0 throughout horizontal and vertical blanking -> rd_fifo stays 0, rgb=0, underflow_cnt unchanged.

Source files
------------

// File: rtl/vga_timing_ctrl_pkg.sv
// Shared VGA timing constants, counter type and controller state encoding.
// Defaults give 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    localparam int unsigned DefHTot = DefHActive + DefHFp + DefHSync + DefHBp;
    localparam int unsigned DefVTot = DefVActive + DefVFp + DefVSync + DefVBp;

    localparam int unsigned CntW = 10;
    typedef logic [CntW-1:0] cnt_t;

    typedef enum logic [1:0] {StIdle, StWaitFill, StRun} state_e;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// FIFO read side and VGA pin bundle of the timing controller.
interface vga_timing_ctrl_if;
    logic        fifo_empty;
    logic [7:0]  pixel_r_in;
    logic [7:0]  pixel_g_in;
    logic [7:0]  pixel_b_in;
    logic        rd_fifo;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;
    logic        underflow;
    logic [15:0] underflow_cnt;

    modport master (
        input  fifo_empty, pixel_r_in, pixel_g_in, pixel_b_in,
        output rd_fifo, hsync, vsync, de, vga_r, vga_g, vga_b,
        output frame_start, underflow, underflow_cnt
    );

    modport slave (
        output fifo_empty, pixel_r_in, pixel_g_in, pixel_b_in,
        input  rd_fifo, hsync, vsync, de, vga_r, vga_g, vga_b,
        input  frame_start, underflow, underflow_cnt
    );
endinterface

// File: rtl/vga_timing_ctrl_sync_counter.sv
// Horizontal/vertical position counters with raw (undelayed, active-high) sync,
// active-window and end-of-frame decode. Counters sit at 0 whenever run is low.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic hsync_raw,
    output logic vsync_raw,
    output logic act,
    output logic eof
);
    localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam cnt_t HLast   = cnt_t'(HTot - 1);
    localparam cnt_t VLast   = cnt_t'(VTot - 1);
    localparam cnt_t HAct    = cnt_t'(H_ACTIVE);
    localparam cnt_t VAct    = cnt_t'(V_ACTIVE);
    localparam cnt_t HsStart = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HsEnd   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VsStart = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VsEnd   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;
    logic h_wrap;

    always_comb begin
        h_wrap  = (h_cnt_q == HLast);
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            v_cnt_d = v_cnt_q;
            if (h_wrap) begin
                v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt     = h_cnt_q;
    assign v_cnt     = v_cnt_q;
    assign act       = run && (h_cnt_q < HAct) && (v_cnt_q < VAct);
    assign hsync_raw = run && (h_cnt_q >= HsStart) && (h_cnt_q < HsEnd);
    assign vsync_raw = run && (v_cnt_q >= VsStart) && (v_cnt_q < VsEnd);
    assign eof       = run && h_wrap && (v_cnt_q == VLast);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: reads pixels from a FIFO during active video and
// drives registered, mutually aligned RGB/sync/de pins, counting FIFO underflows.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter logic        SYNC_POL = 1'b0
) (
    input logic               clk,
    input logic               rst,
    input logic               en,
    vga_timing_ctrl_if.master bus
);
    state_e      state_q, state_d;
    logic        stop_q, stop_d;
    logic        run, act, eof, hs_raw, vs_raw, rd, miss;
    cnt_t        h_cnt, v_cnt;

    // Stage 1 carries the slot descriptor while the FIFO presents its data.
    logic        act_p1_q, act_p1_d, rd_p1_q, rd_p1_d, fs_p1_q, fs_p1_d;
    logic        hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
    logic [23:0] rgb_q, rgb_d;
    logic        uf_q, uf_d;
    logic [15:0] ucnt_q, ucnt_d;

    assign run = (state_q == StRun);

    vga_sync_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_sync_counter (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .hsync_raw(hs_raw),
        .vsync_raw(vs_raw),
        .act      (act),
        .eof      (eof)
    );

    assign rd   = act && !bus.fifo_empty;
    assign miss = act && bus.fifo_empty;

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        unique case (state_q)
            StIdle:     if (en) state_d = StWaitFill;
            StWaitFill: begin
                if (!en)                  state_d = StIdle;
                else if (!bus.fifo_empty) state_d = StRun;
            end
            StRun: begin
                if (!en) stop_d = 1'b1;
                // A stop request always lets the current frame finish first.
                if (eof && (stop_q || !en)) begin
                    state_d = StIdle;
                    stop_d  = 1'b0;
                end
            end
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        act_p1_d = act;
        rd_p1_d  = rd;
        hs_p1_d  = hs_raw;
        vs_p1_d  = vs_raw;
        fs_p1_d  = act && (h_cnt == '0) && (v_cnt == '0);
        hsync_d  = hs_p1_q ? SYNC_POL : ~SYNC_POL;
        vsync_d  = vs_p1_q ? SYNC_POL : ~SYNC_POL;
        de_d     = act_p1_q;
        fs_d     = fs_p1_q;
        rgb_d    = (act_p1_q && rd_p1_q) ?
                   {bus.pixel_r_in, bus.pixel_g_in, bus.pixel_b_in} : 24'h0;
        uf_d     = uf_q | miss;
        ucnt_d   = (miss && (ucnt_q != 16'hFFFF)) ? ucnt_q + 16'd1 : ucnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            stop_q   <= 1'b0;
            act_p1_q <= 1'b0;
            rd_p1_q  <= 1'b0;
            hs_p1_q  <= 1'b0;
            vs_p1_q  <= 1'b0;
            fs_p1_q  <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
            rgb_q    <= '0;
            uf_q     <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            stop_q   <= stop_d;
            act_p1_q <= act_p1_d;
            rd_p1_q  <= rd_p1_d;
            hs_p1_q  <= hs_p1_d;
            vs_p1_q  <= vs_p1_d;
            fs_p1_q  <= fs_p1_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
            rgb_q    <= rgb_d;
            uf_q     <= uf_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign bus.rd_fifo       = rd;
    assign bus.hsync         = hsync_q;
    assign bus.vsync         = vsync_q;
    assign bus.de            = de_q;
    assign bus.frame_start   = fs_q;
    assign bus.vga_r         = rgb_q[23:16];
    assign bus.vga_g         = rgb_q[15:8];
    assign bus.vga_b         = rgb_q[7:0];
    assign bus.underflow     = uf_q;
    assign bus.underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl on a shrunken raster, checked every cycle
// against a frame-position reference model.
module tb_vga_timing_ctrl;
    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
    localparam int HTOT  = HA + HFP + HS + HBP;
    localparam int VTOT  = VA + VFP + VS + VBP;
    localparam int FRAME = HTOT * VTOT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    vga_timing_ctrl_if bus ();

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en (en),
        .bus(bus)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Model: state 0=idle 1=wait-fill 2=run; m_pos is the linear raster position.
    int          m_st, m_pos, e_cnt;
    bit          m_stop;
    bit          p_act, p_rd, p_hs, p_vs, p_fs;
    bit          e_hs, e_vs, e_de, e_fs, e_uf;
    logic [23:0] e_rgb;

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_stop = 0;
        p_act = 0; p_rd = 0; p_hs = 0; p_vs = 0; p_fs = 0;
        e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_uf = 0; e_rgb = '0; e_cnt = 0;
    endtask

    function automatic bit model_act();
        return (m_st == 2) && ((m_pos % HTOT) < HA) && ((m_pos / HTOT) < VA);
    endfunction

    task automatic check_outputs(input bit empty_v);
        check_eq("rd_fifo", 32'(bus.rd_fifo), 32'(model_act() && !empty_v));
        check_eq("hs_vs_de_fs", 32'({bus.hsync, bus.vsync, bus.de, bus.frame_start}),
                 32'({~e_hs, ~e_vs, e_de, e_fs}));
        check_eq("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(e_rgb));
        check_eq("underflow", 32'({bus.underflow, bus.underflow_cnt}),
                 32'({e_uf, e_cnt[15:0]}));
    endtask

    task automatic cycle(input bit rst_v, input bit en_v, input bit empty_v);
        logic [23:0] pix;
        int h, v;
        bit act;
        @(negedge clk);
        rst = rst_v;
        en  = en_v;
        bus.fifo_empty = empty_v;
        pix = 24'($urandom);
        {bus.pixel_r_in, bus.pixel_g_in, bus.pixel_b_in} = pix;
        #1;
        check_outputs(empty_v);
        if (!rst_v) begin
            model_reset();
        end else begin
            h   = m_pos % HTOT;
            v   = m_pos / HTOT;
            act = model_act();
            e_hs  = p_hs;
            e_vs  = p_vs;
            e_de  = p_act;
            e_fs  = p_fs;
            e_rgb = (p_act && p_rd) ? pix : 24'h0;
            if (act && empty_v) begin
                e_uf = 1;
                if (e_cnt < 65535) e_cnt++;
            end
            p_act = act;
            p_rd  = act && !empty_v;
            p_hs  = (m_st == 2) && (h >= HA + HFP) && (h < HA + HFP + HS);
            p_vs  = (m_st == 2) && (v >= VA + VFP) && (v < VA + VFP + VS);
            p_fs  = act && (m_pos == 0);
            case (m_st)
                0: if (en_v) m_st = 1;
                1: begin
                    if (!en_v) m_st = 0;
                    else if (!empty_v) begin m_st = 2; m_pos = 0; end
                end
                default: begin
                    if (!en_v) m_stop = 1;
                    if (m_pos == FRAME - 1) begin
                        m_pos = 0;
                        if (m_stop) begin m_st = 0; m_stop = 0; end
                    end else begin
                        m_pos++;
                    end
                end
            endcase
        end
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * FRAME && !(m_st == 2 && m_pos == target); i++) cycle(1, 1, 0);
    endtask

    initial begin
        model_reset();
        bus.fifo_empty = 1'b1;
        {bus.pixel_r_in, bus.pixel_g_in, bus.pixel_b_in} = '0;

        repeat (5) cycle(0, 0, 1);
        repeat (40) cycle(1, 0, 0);

        // Random occasional underflows over several frames.
        for (int i = 0; i < 3 * FRAME; i++) cycle(1, 1, $urandom_range(0, 29) == 0);

        // Directed 3-slot underflow inside line 2, then check blanking reads nothing.
        run_to(2 * HTOT + 4);
        repeat (3) cycle(1, 1, 1);
        for (int i = 0; i < FRAME; i++) cycle(1, 1, 0);

        // Drop en mid-frame, re-assert before the frame end: frame still completes.
        run_to(3 * HTOT + 5);
        repeat (20) cycle(1, 0, 0);
        for (int i = 0; i < 2 * FRAME; i++) cycle(1, 1, 0);

        // Stop with en held low, sit idle, then restart through wait-fill.
        run_to(HTOT + 1);
        for (int i = 0; i < FRAME + 30; i++) cycle(1, 0, 0);
        repeat (6) cycle(1, 1, 1);
        for (int i = 0; i < FRAME; i++) cycle(1, 1, $urandom_range(0, 15) == 0);

        // Asynchronous reset mid-line while running.
        run_to(4 * HTOT + 7);
        @(negedge clk);
        #7 rst = 1'b0;
        #1;
        model_reset();
        check_outputs(bus.fifo_empty);
        repeat (3) cycle(0, 1, 0);
        for (int i = 0; i < FRAME + 20; i++) cycle(1, 1, 0);

        // Random en and empty mix.
        for (int i = 0; i < 6 * FRAME; i++)
            cycle(1, $urandom_range(0, 99) < 97, $urandom_range(0, 9) == 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
